// File: rtl/reg_file_wb_arbiter_if.sv
// Write-back request bus between the producers and the arbiter.
// The master side is the producers (ALU, load unit, ...), the slave side is the arbiter.
interface reg_file_wb_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/reg_file_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, plus a scoreboard of
// registers with outstanding reserved writes for read-after-write hazard detection.
module reg_file_wb_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_wb_arbiter_if.slave  req,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_reg,
  input  logic [ADDR_WIDTH-1:0] chk_reg_1,
  input  logic [ADDR_WIDTH-1:0] chk_reg_2,
  output logic                  hazard_1,
  output logic                  hazard_2,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_reg,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [31:0]           pending
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       grant_idx, cand;
  logic                  grant_found;
  logic [NUM_REQ-1:0]    ready;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_reg_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [31:0]           pending_q, pending_d;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant_found) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign req.req_ready = ready;

  always_comb begin
    sel_reg  = req.req_reg[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_data = req.req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    ptr_d    = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
  end

  // A reservation in the same cycle as a retiring write wins: a newer producer owns the register.
  always_comb begin
    pending_d = pending_q;
    if (grant_found && (sel_reg != '0)) begin
      pending_d[sel_reg] = 1'b0;
    end
    if (rsv_en && (rsv_reg != '0)) begin
      pending_d[rsv_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (grant_found) begin
        // Writes to x0 are accepted to drain the producer but never reach the register file.
        wr_en_q   <= (sel_reg != '0);
        wr_reg_q  <= sel_reg;
        wr_data_q <= sel_data;
        ptr_q     <= ptr_d;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  // The in-flight write term covers the cycle where the register file has not yet latched it.
  assign hazard_1 = (chk_reg_1 != '0) &&
                    (pending_q[chk_reg_1] || (wr_en_q && (wr_reg_q == chk_reg_1)));
  assign hazard_2 = (chk_reg_2 != '0) &&
                    (pending_q[chk_reg_2] || (wr_en_q && (wr_reg_q == chk_reg_2)));

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;

endmodule

// File: doc/reg_file_wb_arbiter.md
# reg_file_wb_arbiter

Write-back arbiter and hazard scoreboard for the 32x32 register file. Shares the register file's single write port (`wr_en`/`wr_reg`/`wr_data`) among `NUM_REQ` producers, such as the ALU and the load unit, using round-robin arbitration and a valid/ready handshake. Tracks registers that have outstanding reserved writes, so issue logic can stall on read-after-write hazards. Sits between the execute/memory stages and `register_file`.

## Interface
- `NUM_REQ`, 2, number of write-back requesters (2..4)
- `DATA_WIDTH`, 32, write data width
- `ADDR_WIDTH`, 5, register index width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  requester i has a write pending
- `req_ready`  out  NUM_REQ  grant; handshake when valid&ready
- `req_reg`  in  NUM_REQ*ADDR_WIDTH  requester i target at bits [i*5+4:i*5]
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*32+31:i*32]
- `rsv_en`  in  1  reserve a destination register at issue
- `rsv_reg`  in  ADDR_WIDTH  register to reserve
- `chk_reg_1`, `chk_reg_2`  in  ADDR_WIDTH  source registers to hazard-check
- `hazard_1`, `hazard_2`  out  1  source not yet readable
- `wr_en`  out  1  to register_file write enable
- `wr_reg`  out  ADDR_WIDTH  to register_file write index
- `wr_data`  out  DATA_WIDTH  to register_file write data
- `pending`  out  32  scoreboard mask; bit 0 always 0

## Operation
- Round-robin pointer `ptr` (0..NUM_REQ-1). Each cycle, the winner is the first requester with `req_valid` high, searching from `ptr` upward with wrap.
- `req_ready` is combinational and one-hot or zero. It is high only for the winner, and it is never high for a requester whose valid is low.
- On a handshake with winner g: at the next posedge, `wr_en`<=1, `wr_reg`<=req_reg[g], `wr_data`<=req_data[g], and `ptr`<=(g+1) mod NUM_REQ.
- If there is no handshake: `wr_en`<=0, `wr_reg`/`wr_data` hold, `ptr` holds.
- A request targeting x0 is still granted, to drain the producer, but `wr_en` stays 0. `ptr` still advances.
- Scoreboard set: at posedge, when `rsv_en` is high and `rsv_reg`!=0, `pending[rsv_reg]`<=1. A reservation of x0 is ignored.
- Scoreboard clear: at posedge of a handshake to register r!=0, `pending[r]`<=0.
- Set and clear of the same register in one cycle: set wins, because a newer producer owns it.
- `hazard_n` = (`chk_reg_n`!=0) && (`pending[chk_reg_n]` || (`wr_en` && `wr_reg`==`chk_reg_n`)). This is combinational and covers a write in flight to the register file.
- Requesters must hold `req_valid`/`req_reg`/`req_data` stable until accepted. Their data is not checked against the scoreboard.

## Timing
- Reset (async, immediate): `wr_en`=0, `wr_reg`=0, `wr_data`=0, `pending`=0, `ptr`=0. `req_ready` is combinational from valid and `ptr`.
- Reset asserted mid-operation drops any in-flight write (`wr_en` low at once) and clears all reservations.
- Write latency:
  - Handshake in cycle k.
  - `wr_en` high in cycle k+1.
  - register_file updated at the end of k+1.
  - Value readable, with `hazard` low, in cycle k+2.
- Throughput: one write per cycle. Back-to-back grants go to different requesters whenever more than one is valid.
- Starvation bound: a valid requester is granted within NUM_REQ cycles.

## Test plan
- Reset, then idle: `wr_en`=0, `req_ready`=0, `pending`=0, `hazard_1/2`=0 for all `chk_reg` values.
- Both requesters valid continuously:
  - req0 targets x5 with data 0xAAAA0000; req1 targets x6 with data 0x5555FFFF.
  - Required: grants alternate 0,1,0,1.
  - Required: `wr_en` is high every cycle from the second cycle on.
  - Required: `wr_reg` alternates 5,6 one cycle after each grant.
- Reserve x7, then check x7:
  - `hazard_1`=1 from the cycle after reservation.
  - After req1 writes x7 with 0x12345678, `hazard_1` stays 1 during the `wr_en` cycle and is 0 the cycle after.
  - register_file then reads 0x12345678.
- Reserve x9 in the same cycle as a handshake to x9: `pending[9]` remains 1 afterwards.
- Request to x0 with 0xFFFFFFFF:
  - `req_ready`=1.
  - `wr_en` stays 0.
  - A reservation of x0 leaves `pending`=0, and `hazard` is 0 for x0.
- Assert `rst` while `wr_en`=1 and `pending`=0x00000080: outputs return to 0 without waiting for a clock edge, and the arbiter restarts at requester 0.
